adc_avg: RTL and testbench

ADC_AVG -- requirements
Module: adc_avg

---
 rtl/adc_avg_pkg.sv | 19 +
 rtl/adc_chan_acc.sv | 72 +++++++
 rtl/adc_avg.sv | 77 +++++++
 tb/tb_adc_avg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/adc_avg_pkg.sv
// Shared constants and types for the ADC block averager.
// Widths, block depth, hysteresis thresholds and the averager state encoding.
package adc_avg_pkg;

    localparam int unsigned bits     = 12;
    localparam int unsigned inputs   = 2;
    localparam int unsigned avg_log2 = 4;

    localparam int unsigned hi_set = 'hC00;
    localparam int unsigned hi_clr = 'hA00;
    localparam int unsigned lo_set = 'h400;
    localparam int unsigned lo_clr = 'h600;

    typedef enum logic {
        StIdle,
        StAccum
    } avg_state_e;

endpackage

// File: rtl/adc_chan_acc.sv
// One channel of the block averager: running sum, average register and hi/lo hysteresis flags.
// The flags are computed from the new average so they change together with avg.
module adc_chan_acc
    import adc_avg_pkg::*;
#(
    parameter int unsigned BITS       = bits,
    parameter int unsigned LOG2_DEPTH = avg_log2,
    parameter int unsigned HI_SET     = hi_set,
    parameter int unsigned HI_CLR     = hi_clr,
    parameter int unsigned LO_SET     = lo_set,
    parameter int unsigned LO_CLR     = lo_clr
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            strobe,
    input  logic            last,
    input  logic [BITS-1:0] sample,
    output logic [BITS-1:0] avg,
    output logic            hi,
    output logic            lo
);

    localparam int unsigned AccW = BITS + LOG2_DEPTH;

    localparam logic [BITS-1:0] HiSetV = BITS'(HI_SET);
    localparam logic [BITS-1:0] HiClrV = BITS'(HI_CLR);
    localparam logic [BITS-1:0] LoSetV = BITS'(LO_SET);
    localparam logic [BITS-1:0] LoClrV = BITS'(LO_CLR);

    logic [AccW-1:0] acc;
    logic [AccW-1:0] sum;
    logic [BITS-1:0] avg_new;
    logic            hi_new;
    logic            lo_new;

    assign sum     = acc + AccW'(sample);
    assign avg_new = sum[AccW-1:LOG2_DEPTH];

    always_comb begin
        hi_new = hi;
        if (avg_new >= HiSetV) begin
            hi_new = 1'b1;
        end else if (avg_new < HiClrV) begin
            hi_new = 1'b0;
        end
        lo_new = lo;
        if (avg_new <= LoSetV) begin
            lo_new = 1'b1;
        end else if (avg_new > LoClrV) begin
            lo_new = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            avg <= '0;
            hi  <= 1'b0;
            lo  <= 1'b0;
        end else if (strobe) begin
            if (last) begin
                acc <= '0;
                avg <= avg_new;
                hi  <= hi_new;
                lo  <= lo_new;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/adc_avg.sv
// Multi-channel block averager: counts done rising edges and emits one average per DEPTH samples.
// Shared strobe/last control drives one adc_chan_acc per channel.
module adc_avg
    import adc_avg_pkg::*;
#(
    parameter int unsigned BITS       = bits,
    parameter int unsigned INPUTS     = inputs,
    parameter int unsigned LOG2_DEPTH = avg_log2,
    parameter int unsigned HI_SET     = hi_set,
    parameter int unsigned HI_CLR     = hi_clr,
    parameter int unsigned LO_SET     = lo_set,
    parameter int unsigned LO_CLR     = lo_clr
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INPUTS-1:0][BITS-1:0] in,
    input  logic                        done,
    output logic [INPUTS-1:0][BITS-1:0] avg,
    output logic                        valid,
    output logic [INPUTS-1:0]           hi,
    output logic [INPUTS-1:0]           lo
);

    avg_state_e            state;
    logic                  done_q;
    logic                  armed;
    logic [LOG2_DEPTH-1:0] count;
    logic                  strobe;
    logic                  last;

    // armed stays low for the first clock after reset so a done already high is not counted
    assign strobe = done && !done_q && (armed || state == StAccum);
    assign last   = (count == {LOG2_DEPTH{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            done_q <= 1'b0;
            armed  <= 1'b0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            done_q <= done;
            armed  <= 1'b1;
            valid  <= strobe && last;
            if (strobe) begin
                count <= count + 1'b1;
            end
            case (state)
                StIdle:  if (strobe) state <= StAccum;
                StAccum: state <= StAccum;
                default: state <= StIdle;
            endcase
        end
    end

    for (genvar i = 0; i < INPUTS; i++) begin : g_chan
        adc_chan_acc #(
            .BITS      (BITS),
            .LOG2_DEPTH(LOG2_DEPTH),
            .HI_SET    (HI_SET),
            .HI_CLR    (HI_CLR),
            .LO_SET    (LO_SET),
            .LO_CLR    (LO_CLR)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .strobe(strobe),
            .last  (last),
            .sample(in[i]),
            .avg   (avg[i]),
            .hi    (hi[i]),
            .lo    (lo[i])
        );
    end

endmodule

// File: tb/tb_adc_avg.sv
// Self-checking bench for adc_avg: directed and random sample blocks against a sum/divide model.
module tb_adc_avg;

    localparam int Depth = 16;

    logic             clk;
    logic             rst;
    logic [1:0][11:0] in_s;
    logic             done;
    logic [1:0][11:0] avg;
    logic             valid;
    logic [1:0]       hi;
    logic [1:0]       lo;

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    int blocks = 0;

    // Reference model state
    int unsigned m_sum [2];
    int          m_n;
    bit          m_hi  [2];
    bit          m_lo  [2];
    int unsigned m_avg [2];

    adc_avg dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in_s),
        .done (done),
        .avg  (avg),
        .valid(valid),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (valid === 1'b1) vcount++;
        check("hi_lo_exclusive", 32'(hi & lo), 32'd0);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_sum[c] = 0;
            m_hi[c]  = 0;
            m_lo[c]  = 0;
            m_avg[c] = 0;
        end
        m_n = 0;
    endtask

    // One sample: done high for hold cycles, then low for gap cycles.
    task automatic strobe(input logic [11:0] a, input logic [11:0] b, input int hold, input int gap);
        bit blk;
        in_s[0] = a;
        in_s[1] = b;
        done    = 1'b1;
        m_sum[0] += a;
        m_sum[1] += b;
        m_n++;
        blk = (m_n == Depth);
        if (blk) begin
            for (int c = 0; c < 2; c++) begin
                m_avg[c] = m_sum[c] / Depth;
                if (m_avg[c] >= 'hC00) m_hi[c] = 1;
                else if (m_avg[c] < 'hA00) m_hi[c] = 0;
                if (m_avg[c] <= 'h400) m_lo[c] = 1;
                else if (m_avg[c] > 'h600) m_lo[c] = 0;
                m_sum[c] = 0;
            end
            m_n = 0;
            blocks++;
        end
        tick();
        check("valid_after_strobe", 32'(valid), 32'(blk));
        if (blk) begin
            check("avg0", 32'(avg[0]), m_avg[0]);
            check("avg1", 32'(avg[1]), m_avg[1]);
            check("hi", 32'(hi), {30'd0, m_hi[1], m_hi[0]});
            check("lo", 32'(lo), {30'd0, m_lo[1], m_lo[0]});
        end
        // Change the bus after capture; later samples must not be re-read
        in_s[0] = 12'($urandom);
        in_s[1] = 12'($urandom);
        for (int k = 1; k < hold; k++) begin
            tick();
            check("valid_hold", 32'(valid), 32'd0);
        end
        done = 1'b0;
        for (int k = 0; k < gap; k++) begin
            tick();
            check("valid_gap", 32'(valid), 32'd0);
        end
        check("avg0_stable", 32'(avg[0]), m_avg[0]);
        check("avg1_stable", 32'(avg[1]), m_avg[1]);
    endtask

    task automatic block(input logic [11:0] a, input logic [11:0] b);
        for (int s = 0; s < Depth; s++) strobe(a, b, 1, 1);
    endtask

    initial begin
        rst  = 1'b1;
        done = 1'b0;
        in_s = '0;
        model_reset();
        #23;
        check("rst_avg", 32'(avg), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_hi", 32'(hi), 32'd0);
        check("rst_lo", 32'(lo), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Constant mid/low levels
        block(12'h800, 12'h100);
        check("c1_avg0", 32'(avg[0]), 32'h800);
        check("c1_avg1", 32'(avg[1]), 32'h100);
        check("c1_lo1", 32'(lo[1]), 32'd1);
        check("c1_hi0", 32'(hi[0]), 32'd0);
        check("c1_vcount", 32'(vcount), 32'd1);

        // Ramp, truncating divide
        for (int s = 0; s < Depth; s++) strobe(12'(s), 12'h200, 1, 1);
        check("ramp_avg0", 32'(avg[0]), 32'h007);

        // Full scale, no wrap
        block(12'hFFF, 12'hFFF);
        check("full_avg", 32'(avg), {8'd0, 12'hFFF, 12'hFFF});

        // Long done pulses count once each
        for (int s = 0; s < Depth; s++) strobe(12'h300, 12'h900, 5, 1);
        check("long_done_vcount", 32'(vcount), 32'(blocks));

        // Reset mid-block, with done high across deassertion
        for (int s = 0; s < 8; s++) strobe(12'h123, 12'h456, 1, 1);
        done = 1'b1;
        rst  = 1'b1;
        #2;
        check("mid_rst_avg", 32'(avg), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_no_valid", 32'(valid), 32'd0);
        end
        done = 1'b0;
        tick();
        block(12'h400, 12'h400);
        check("post_rst_avg", 32'(avg), {8'd0, 12'h400, 12'h400});

        // Hysteresis on ch0
        block(12'hC80, 12'h800);
        check("hys1_hi0", 32'(hi[0]), 32'd1);
        check("hys1_lo0", 32'(lo[0]), 32'd0);
        block(12'hB00, 12'h800);
        check("hys2_hi0", 32'(hi[0]), 32'd1);
        check("hys2_lo0", 32'(lo[0]), 32'd0);
        block(12'h900, 12'h800);
        check("hys3_hi0", 32'(hi[0]), 32'd0);
        check("hys3_lo0", 32'(lo[0]), 32'd0);

        // Random blocks with random pulse shapes
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < Depth; s++) begin
                strobe(12'($urandom), 12'($urandom), int'($urandom_range(1, 4)),
                       int'($urandom_range(1, 3)));
            end
        end

        check("total_valids", 32'(vcount), 32'(blocks));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
